// File: rtl/posicionador_porta_avioes.sv
// ---------------------------------------------------------------------------
// posicionador_porta_avioes
//
// Placement controller for the 5-cell aircraft carrier on the 8x8 board.
// The player moves and rotates the carrier with debounced push-button levels
// and then locks it. The five cell coordinates are packed into the 64-bit
// bus that the VGA renderer decodes.
//
// Ports
//   clk                 in   1   system clock
//   rst_n               in   1   asynchronous reset, active low
//   btn_cima            in   1   debounced level: move up    (Y+1)
//   btn_baixo           in   1   debounced level: move down  (Y-1)
//   btn_esq             in   1   debounced level: move left  (X-1)
//   btn_dir             in   1   debounced level: move right (X+1)
//   btn_girar           in   1   debounced level: toggle horizontal/vertical
//   btn_confirmar       in   1   debounced level: lock placement
//   novo_jogo           in   1   while high, return to placement at home position
//   posicoesEmbarcacao  out  64  packed cells, registered
//   horizontal          out  1   1 = cells extend along +X, 0 = along +Y
//   pronto              out  1   1 = placement locked
//
// Bus layout: cell k (k = 0..4) keeps X_k in bits [6+8k -: 4] and Y_k in
// bits [10+8k -: 4]. Bits 2:0 and 63:43 are always zero.
// ---------------------------------------------------------------------------
module posicionador_porta_avioes #(
  parameter int TAM_MAPA  = 8,
  parameter int TAM_NAVIO = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_cima,
  input  logic        btn_baixo,
  input  logic        btn_esq,
  input  logic        btn_dir,
  input  logic        btn_girar,
  input  logic        btn_confirmar,
  input  logic        novo_jogo,
  output logic [63:0] posicoesEmbarcacao,
  output logic        horizontal,
  output logic        pronto
);

  typedef enum logic {
    POSICIONANDO = 1'b0,
    CONFIRMADO   = 1'b1
  } estado_t;

  // Board limits as 5-bit values so that anchor + extent never wraps.
  localparam logic [4:0] MAPA5      = 5'(TAM_MAPA);
  localparam logic [4:0] EXTENSAO5  = 5'(TAM_NAVIO - 1);
  // Largest anchor coordinate along the carrier's long axis (4 on 8x8).
  localparam logic [3:0] MAX_ANCORA = 4'(TAM_MAPA - TAM_NAVIO + 1);

  // Home position: anchor (1,1), horizontal.
  localparam logic [3:0]  X_INICIAL   = 4'd1;
  localparam logic [3:0]  Y_INICIAL   = 4'd1;
  localparam logic [63:0] BUS_INICIAL = 64'h0000_00A8_A098_9088;

  // Button vector bit positions, highest priority first.
  localparam int B_CONFIRMAR = 5;
  localparam int B_GIRAR     = 4;
  localparam int B_CIMA      = 3;
  localparam int B_BAIXO     = 2;
  localparam int B_ESQ       = 1;
  localparam int B_DIR       = 0;

  // Packs the five carrier cells derived from an anchor and orientation.
  function automatic logic [63:0] empacota(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       h);
    logic [63:0] bus;
    logic [3:0]  xk;
    logic [3:0]  yk;
    bus = 64'd0;
    for (int k = 0; k < 5; k++) begin
      if (h) begin
        xk = x + 4'(k);
        yk = y;
      end else begin
        xk = x;
        yk = y + 4'(k);
      end
      bus[6 + 8*k -: 4]  = xk;
      bus[10 + 8*k -: 4] = yk;
    end
    return bus;
  endfunction

  // True when every cell of a carrier anchored at (x,y) lies inside the board.
  function automatic logic cabe(input logic [4:0] x,
                                input logic [4:0] y,
                                input logic       h);
    logic [4:0] x_fim;
    logic [4:0] y_fim;
    if (h) begin
      x_fim = x + EXTENSAO5;
      y_fim = y;
    end else begin
      x_fim = x;
      y_fim = y + EXTENSAO5;
    end
    return (x >= 5'd1) && (y >= 5'd1) && (x_fim <= MAPA5) && (y_fim <= MAPA5);
  endfunction

  estado_t     estado_q, estado_d;
  logic [3:0]  x_q, x_d;
  logic [3:0]  y_q, y_d;
  logic        horizontal_q, horizontal_d;
  logic        pronto_q, pronto_d;
  logic [63:0] bus_q, bus_d;
  logic [5:0]  btn_q, btn_d;

  logic [5:0]  btn_s;
  logic [5:0]  evt_s;
  logic        mover_s;
  logic [4:0]  cand_x_s;
  logic [4:0]  cand_y_s;

  assign btn_s = {btn_confirmar, btn_girar, btn_cima, btn_baixo, btn_esq, btn_dir};
  // Rising edge against last cycle's sample: a held button fires once.
  assign evt_s = btn_s & ~btn_q;

  // Next-state computation: novo_jogo, then one event by priority.
  always_comb begin
    estado_d     = estado_q;
    x_d          = x_q;
    y_d          = y_q;
    horizontal_d = horizontal_q;
    pronto_d     = pronto_q;
    btn_d        = btn_s;
    mover_s      = 1'b0;
    cand_x_s     = {1'b0, x_q};
    cand_y_s     = {1'b0, y_q};

    if (novo_jogo) begin
      estado_d     = POSICIONANDO;
      x_d          = X_INICIAL;
      y_d          = Y_INICIAL;
      horizontal_d = 1'b1;
      pronto_d     = 1'b0;
    end else begin
      case (estado_q)
        POSICIONANDO: begin
          if (evt_s[B_CONFIRMAR]) begin
            estado_d = CONFIRMADO;
            pronto_d = 1'b1;
          end else if (evt_s[B_GIRAR]) begin
            horizontal_d = ~horizontal_q;
            // Rotation keeps the anchor but pulls the new long axis back inside.
            if (!horizontal_q) begin
              if (x_q > MAX_ANCORA) begin
                x_d = MAX_ANCORA;
              end else begin
                x_d = x_q;
              end
            end else begin
              if (y_q > MAX_ANCORA) begin
                y_d = MAX_ANCORA;
              end else begin
                y_d = y_q;
              end
            end
          end else if (evt_s[B_CIMA]) begin
            mover_s  = 1'b1;
            cand_y_s = {1'b0, y_q} + 5'd1;
          end else if (evt_s[B_BAIXO]) begin
            mover_s  = 1'b1;
            cand_y_s = {1'b0, y_q} - 5'd1;
          end else if (evt_s[B_ESQ]) begin
            mover_s  = 1'b1;
            cand_x_s = {1'b0, x_q} - 5'd1;
          end else if (evt_s[B_DIR]) begin
            mover_s  = 1'b1;
            cand_x_s = {1'b0, x_q} + 5'd1;
          end else begin
            mover_s = 1'b0;
          end

          // Out-of-board moves are dropped; 1-1 underflows to 0 and fails too.
          if (mover_s && cabe(cand_x_s, cand_y_s, horizontal_q)) begin
            x_d = cand_x_s[3:0];
            y_d = cand_y_s[3:0];
          end else begin
            mover_s = 1'b0;
          end
        end
        CONFIRMADO: begin
          estado_d = CONFIRMADO;
        end
        default: begin
          estado_d     = POSICIONANDO;
          x_d          = X_INICIAL;
          y_d          = Y_INICIAL;
          horizontal_d = 1'b1;
          pronto_d     = 1'b0;
        end
      endcase
    end

    // Bus follows the next anchor/orientation so it updates on the same edge.
    bus_d = empacota(x_d, y_d, horizontal_d);
  end

  // State, anchor, outputs and button samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= POSICIONANDO;
      x_q          <= X_INICIAL;
      y_q          <= Y_INICIAL;
      horizontal_q <= 1'b1;
      pronto_q     <= 1'b0;
      bus_q        <= BUS_INICIAL;
      btn_q        <= 6'b00_0000;
    end else begin
      estado_q     <= estado_d;
      x_q          <= x_d;
      y_q          <= y_d;
      horizontal_q <= horizontal_d;
      pronto_q     <= pronto_d;
      bus_q        <= bus_d;
      btn_q        <= btn_d;
    end
  end

  assign posicoesEmbarcacao = bus_q;
  assign horizontal         = horizontal_q;
  assign pronto             = pronto_q;

endmodule

// File: tb/tb_posicionador_porta_avioes.sv
module tb_posicionador_porta_avioes;

  logic        clk;
  logic        rst_n;
  logic [5:0]  btns;   // {confirmar, girar, cima, baixo, esq, dir}
  logic        novo_jogo;
  logic [63:0] bus;
  logic        horizontal;
  logic        pronto;

  int n_total;
  int n_pass;

  localparam int B_CONFIRMAR = 5;
  localparam int B_GIRAR     = 4;
  localparam int B_CIMA      = 3;
  localparam int B_BAIXO     = 2;
  localparam int B_ESQ       = 1;
  localparam int B_DIR       = 0;

  localparam logic [63:0] BUS_RESET = 64'h0000_00A8_A098_9088;

  posicionador_porta_avioes dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .btn_cima           (btns[B_CIMA]),
    .btn_baixo          (btns[B_BAIXO]),
    .btn_esq            (btns[B_ESQ]),
    .btn_dir            (btns[B_DIR]),
    .btn_girar          (btns[B_GIRAR]),
    .btn_confirmar      (btns[B_CONFIRMAR]),
    .novo_jogo          (novo_jogo),
    .posicoesEmbarcacao (bus),
    .horizontal         (horizontal),
    .pronto             (pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int b);
    btns[b] = 1'b1;
    tick();
    btns[b] = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    btns      = 6'b00_0000;
    novo_jogo = 1'b0;
    #12;
    check("reset_bus", bus, BUS_RESET);
    check("reset_horizontal", {63'd0, horizontal}, 64'd1);
    check("reset_pronto", {63'd0, pronto}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Three right pulses: anchor (4,1)
    pulse(B_DIR);
    pulse(B_DIR);
    pulse(B_DIR);
    check("dir_x3_bus", bus, 64'h0000_00C0_B8B0_A8A0);

    // Hold up for 10 cycles: exactly one Y step
    btns[B_CIMA] = 1'b1;
    tick();
    check("cima_first_edge_y", {60'd0, bus[10:7]}, 64'd2);
    for (int i = 0; i < 9; i++) tick();
    check("cima_held_bus", bus, 64'h0000_0141_3931_2920);
    check("cima_held_cellA_x", {60'd0, bus[6:3]}, 64'd4);
    check("cima_held_cellE_x", {60'd0, bus[38:35]}, 64'd8);
    check("cima_held_cellE_y", {60'd0, bus[42:39]}, 64'd2);
    btns[B_CIMA] = 1'b0;
    tick();

    // Right edge: (4,2) horizontal cannot move right
    pulse(B_DIR);
    check("boundary_dir", bus, 64'h0000_0141_3931_2920);

    // Up to Y=8; the seventh press hits the top edge
    for (int i = 0; i < 7; i++) pulse(B_CIMA);
    check("top_edge_bus", bus, 64'h0000_0444_3C34_2C20);

    // Rotate at (4,8): vertical with Y clamped to 4
    pulse(B_GIRAR);
    check("girar_clamp_bus", bus, 64'h0000_0423_A322_A220);
    check("girar_clamp_horizontal", {63'd0, horizontal}, 64'd0);
    check("girar_clamp_cellE", {56'd0, bus[42:35]}, {56'd0, 4'd8, 4'd4});

    // Left to (3,4), then rotate and right on the same edge
    pulse(B_ESQ);
    btns[B_GIRAR] = 1'b1;
    btns[B_DIR]   = 1'b1;
    tick();
    check("simult_bus", bus, 64'h0000_023A_322A_2218);
    check("simult_horizontal", {63'd0, horizontal}, 64'd1);
    btns[B_GIRAR] = 1'b0;
    tick();
    tick();
    check("simult_dir_held", bus, 64'h0000_023A_322A_2218);
    btns[B_DIR] = 1'b0;
    tick();
    pulse(B_DIR);
    check("dir_repress_bus", bus, 64'h0000_0242_3A32_2A20);

    // Lock
    btns[B_CONFIRMAR] = 1'b1;
    tick();
    check("confirm_pronto", {63'd0, pronto}, 64'd1);
    btns[B_CONFIRMAR] = 1'b0;
    tick();
    pulse(B_CIMA);
    check("locked_cima_bus", bus, 64'h0000_0242_3A32_2A20);
    check("locked_pronto", {63'd0, pronto}, 64'd1);

    // New game with up held across the return
    btns[B_CIMA] = 1'b1;
    tick();
    novo_jogo = 1'b1;
    tick();
    check("novo_jogo_pronto", {63'd0, pronto}, 64'd0);
    check("novo_jogo_bus", bus, BUS_RESET);
    check("novo_jogo_horizontal", {63'd0, horizontal}, 64'd1);
    novo_jogo = 1'b0;
    tick();
    check("held_cima_after_novo", bus, BUS_RESET);
    btns[B_CIMA] = 1'b0;
    tick();

    // Bottom-left corner
    pulse(B_ESQ);
    check("boundary_esq", bus, BUS_RESET);
    pulse(B_BAIXO);
    check("boundary_baixo", bus, BUS_RESET);

    // Move, then async reset mid-cycle during a press
    pulse(B_DIR);
    check("dir_from_home", bus, 64'h0000_00B0_A8A0_9890);
    btns[B_DIR] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_bus", bus, BUS_RESET);
    check("async_reset_horizontal", {63'd0, horizontal}, 64'd1);
    check("async_reset_pronto", {63'd0, pronto}, 64'd0);
    btns = 6'b00_0000;
    tick();
    rst_n = 1'b1;
    tick();

    // Confirm outranks a simultaneous move
    btns[B_CONFIRMAR] = 1'b1;
    btns[B_CIMA]      = 1'b1;
    tick();
    check("prio_confirm_pronto", {63'd0, pronto}, 64'd1);
    check("prio_confirm_bus", bus, BUS_RESET);
    btns = 6'b00_0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
